rca_mw_seq: RTL and testbench



---
 rtl/rca_mw_seq_pkg.sv | 16 +
 rtl/rca_clk.sv | 62 ++++++
 rtl/rca_mw_seq.sv | 115 +++++++++++
 tb/tb_rca_mw_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_mw_seq_pkg.sv
// Shared definitions for the multi-word add sequencer and its word adder.
//   W_DEFAULT : default adder word width
//   state_t   : sequencer state encoding (3-bit)
package rca_mw_seq_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage : rca_mw_seq_pkg

// File: rtl/rca_clk.sv
// Clocked ripple-carry adder stage: registered inputs, combinational ripple,
// registered outputs. A result is visible two edges after its operands.
// Ports:
//   clk       rising-edge clock
//   srst      synchronous active-high reset
//   a, b, ci  operands and carry-in (registered on entry)
//   s, co     registered sum and carry-out
module rca_clk
    import rca_mw_seq_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic         ci_reg;
    logic [W-1:0] s_reg;
    logic         co_reg;
    logic [W-1:0] sum_next;
    logic         co_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            ci_reg <= 1'b0;
            s_reg  <= '0;
            co_reg <= 1'b0;
        end else begin
            a_reg  <= a;
            b_reg  <= b;
            ci_reg <= ci;
            s_reg  <= sum_next;
            co_reg <= co_next;
        end
    end

    // Bit-serial ripple; the running carry is a block-local variable so the
    // chain does not form a feedback loop on a single vector net.
    always_comb begin
        logic c;
        sum_next = '0;
        c        = ci_reg;
        for (int i = 0; i < W; i++) begin
            sum_next[i] = a_reg[i] ^ b_reg[i] ^ c;
            c           = (a_reg[i] & b_reg[i]) | (c & (a_reg[i] ^ b_reg[i]));
        end
        co_next = c;
    end

    assign s  = s_reg;
    assign co = co_reg;

endmodule : rca_clk

// File: rtl/rca_mw_seq.sv
// Multi-word add sequencer. Adds two WORDS*W-bit operands by issuing one W-bit
// word at a time (LSW first) into an external clocked adder (rca_clk) and
// chaining its carry-out into the next word's carry-in.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   start                request; accepted when start=1 and busy=0
//   a_in, b_in, ci_in    operands, sampled on accept
//   busy                 high while a word is in flight (ISSUE/WAIT/CAPTURE)
//   done                 one-cycle pulse when sum/cout are valid
//   sum, cout            registered result, held until next accept or reset
//   add_a, add_b, add_ci drive the adder (zero outside ISSUE)
//   add_s, add_co        adder result, valid in CAPTURE
module rca_mw_seq
    import rca_mw_seq_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WORDS*W-1:0] a_in,
    input  logic [WORDS*W-1:0] b_in,
    input  logic               ci_in,
    output logic               busy,
    output logic               done,
    output logic [WORDS*W-1:0] sum,
    output logic               cout,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_ci,
    input  logic [W-1:0]       add_s,
    input  logic               add_co
);

    localparam int             IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(WORDS - 1);

    state_t                    state_reg;
    state_t                    state_next;
    logic [IW-1:0]             idx_reg;
    logic                      carry_reg;
    logic [WORDS-1:0][W-1:0]   op_a_reg;
    logic [WORDS-1:0][W-1:0]   op_b_reg;
    logic [WORDS-1:0][W-1:0]   sum_reg;
    logic                      cout_reg;
    logic                      accept;
    logic                      last_word;

    assign busy      = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) ||
                       (state_reg == ST_CAPTURE);
    assign done      = (state_reg == ST_DONE);
    assign accept    = start && !busy;
    assign last_word = (idx_reg == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg  <= a_in;
                op_b_reg  <= b_in;
                carry_reg <= ci_in;
                idx_reg   <= '0;
                sum_reg   <= '0;
                cout_reg  <= 1'b0;
            end else if (state_reg == ST_CAPTURE) begin
                sum_reg[idx_reg] <= add_s;
                carry_reg        <= add_co;
                if (last_word) begin
                    cout_reg <= add_co;
                end else begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = ST_WAIT;
            ST_WAIT:    state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = last_word ? ST_DONE : ST_ISSUE;
            // start here is a back-to-back accept
            ST_DONE:    state_next = start ? ST_ISSUE : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Adder inputs are only non-zero during ISSUE; the adder latches them on
    // the edge that leaves ISSUE.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        if (state_reg == ST_ISSUE) begin
            add_a  = op_a_reg[idx_reg];
            add_b  = op_b_reg[idx_reg];
            add_ci = carry_reg;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule : rca_mw_seq

// File: tb/tb_rca_mw_seq.sv
// Bench for rca_mw_seq connected to a real rca_clk adder.
module tb_rca_mw_seq;

    localparam int W     = 32;
    localparam int WORDS = 4;
    localparam int OW    = W * WORDS;
    localparam int LAT   = 3 * WORDS + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [OW-1:0] a_in, b_in;
    logic          ci_in;
    logic          busy, done, cout;
    logic [OW-1:0] sum;
    logic [W-1:0]  add_a, add_b, add_s;
    logic          add_ci, add_co;
    logic          add_srst;

    assign add_srst = ~reset_n;

    always #5 clk = ~clk;

    rca_mw_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co)
    );

    rca_clk #(.W(W)) u_add (
        .clk(clk), .srst(add_srst), .a(add_a), .b(add_b), .ci(add_ci),
        .s(add_s), .co(add_co)
    );

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          ci;
        logic [OW-1:0] exp_sum;
        logic          exp_cout;
    } vec_t;

    typedef struct {
        logic [OW-1:0] sum;
        logic          cout;
    } exp_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [OW-1:0] act,
                         input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] rnd_op();
        logic [OW-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic logic [W-1:0] word_of(input logic [OW-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    // Carry entering word k of a + b + ci.
    function automatic logic carry_into(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                        input logic ci, input int k);
        logic [W:0] t;
        logic       c;
        c = ci;
        for (int j = 0; j < k; j++) begin
            t = {1'b0, word_of(a, j)} + {1'b0, word_of(b, j)} + {{W{1'b0}}, c};
            c = t[W];
        end
        return c;
    endfunction

    task automatic pop_and_compare(input string tag);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_queue: got done with empty scoreboard, expected none", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, sum, e.sum);
            check({tag, "_cout"}, {{(OW-1){1'b0}}, cout}, {{(OW-1){1'b0}}, e.cout});
            $display("%s: sum=%h cout=%0b", tag, sum, cout);
        end
    endtask

    // Wait for done starting in cycle 1; returns the cycle it appeared, -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    // One full operation with per-cycle checks of busy and the adder inputs.
    task automatic run_op(input vec_t v, input bit noise, input string tag);
        exp_t e;
        int   dcyc;
        int   k;
        logic exp_busy;
        logic [W-1:0] ea, eb;
        logic ec;
        e.sum  = v.exp_sum;
        e.cout = v.exp_cout;
        sb_q.push_back(e);
        a_in = v.a; b_in = v.b; ci_in = v.ci; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = rnd_op(); b_in = rnd_op(); ci_in = ~v.ci;
        dcyc = -1;
        for (int c = 1; c <= 30; c++) begin
            exp_busy = (c <= 3 * WORDS);
            check({tag, "_busy"}, {{(OW-1){1'b0}}, busy}, {{(OW-1){1'b0}}, exp_busy});
            k  = (c - 1) / 3;
            ea = '0; eb = '0; ec = 1'b0;
            if ((c % 3 == 1) && (k < WORDS)) begin
                ea = word_of(v.a, k);
                eb = word_of(v.b, k);
                ec = carry_into(v.a, v.b, v.ci, k);
            end
            check({tag, "_add_a"}, {{(OW-W){1'b0}}, add_a}, {{(OW-W){1'b0}}, ea});
            check({tag, "_add_b"}, {{(OW-W){1'b0}}, add_b}, {{(OW-W){1'b0}}, eb});
            check({tag, "_add_ci"}, {{(OW-1){1'b0}}, add_ci}, {{(OW-1){1'b0}}, ec});
            if (done) begin
                dcyc = c;
                break;
            end
            // ignored-start noise in cycles 2..8
            start = noise && (c + 1 >= 2) && (c + 1 <= 8);
            if (start) begin
                a_in = rnd_op(); b_in = rnd_op();
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, OW'(dcyc), OW'(LAT));
        pop_and_compare(tag);
        for (int i = 0; i < (noise ? 4 : 1); i++) begin
            tick();
            check({tag, "_idle_done"}, {{(OW-1){1'b0}}, done}, '0);
            check({tag, "_idle_busy"}, {{(OW-1){1'b0}}, busy}, '0);
            check({tag, "_hold_sum"}, sum, v.exp_sum);
        end
    endtask

    initial begin
        vec_t v1, v2;
        int   dcyc;
        exp_t e;
        logic [OW:0] t;

        vecs[0] = '{{WORDS{32'hFFFF_FFFF}}, '0, 1'b1, '0, 1'b1};
        vecs[1] = '{128'h00000001_00000000_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0,
                    128'h00000001_00000001_00000000_00000000, 1'b0};
        vecs[2] = '{128'h00000004_00000003_00000002_00000001,
                    128'h00000010_00000020_00000030_00000040, 1'b0,
                    128'h00000014_00000023_00000032_00000041, 1'b0};
        vecs[3] = '{{WORDS{32'hFFFF_FFFF}}, {WORDS{32'hFFFF_FFFF}}, 1'b1,
                    {WORDS{32'hFFFF_FFFF}}, 1'b1};
        vecs[4] = '{128'h80000000_00000000_00000000_00000000,
                    128'h80000000_00000000_00000000_00000000, 1'b0, '0, 1'b1};
        vecs[5] = '{'0, '0, 1'b0, '0, 1'b0};
        for (int i = 6; i < NVEC; i++) begin
            vecs[i].a  = rnd_op();
            vecs[i].b  = rnd_op();
            vecs[i].ci = 1'($urandom_range(0, 1));
            t = {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + {{OW{1'b0}}, vecs[i].ci};
            vecs[i].exp_sum  = t[OW-1:0];
            vecs[i].exp_cout = t[OW];
        end

        // reset state
        reset_n = 1'b0; start = 1'b0; a_in = rnd_op(); b_in = rnd_op(); ci_in = 1'b1;
        repeat (3) tick();
        check("rst_busy", {{(OW-1){1'b0}}, busy}, '0);
        check("rst_done", {{(OW-1){1'b0}}, done}, '0);
        check("rst_sum", sum, '0);
        check("rst_cout", {{(OW-1){1'b0}}, cout}, '0);
        check("rst_add_a", {{(OW-W){1'b0}}, add_a}, '0);
        reset_n = 1'b1;
        tick();

        // table-driven vectors; vector 2 also carries ignored-start noise
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], (i == 2), $sformatf("vec%0d", i));
        end

        // reset mid-operation
        a_in = vecs[3].a; b_in = vecs[3].b; ci_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_busy", {{(OW-1){1'b0}}, busy}, '0);
        check("midrst_done", {{(OW-1){1'b0}}, done}, '0);
        check("midrst_sum", sum, '0);
        check("midrst_cout", {{(OW-1){1'b0}}, cout}, '0);
        $display("midrst: sum=%h cout=%0b busy=%0b", sum, cout, busy);
        tick();
        run_op(vecs[1], 1'b0, "after_rst");

        // back-to-back: start held high through DONE
        v1 = vecs[6];
        v2 = vecs[7];
        e.sum = v1.exp_sum; e.cout = v1.exp_cout; sb_q.push_back(e);
        e.sum = v2.exp_sum; e.cout = v2.exp_cout; sb_q.push_back(e);
        a_in = v1.a; b_in = v1.b; ci_in = v1.ci; start = 1'b1;
        tick();
        a_in = v2.a; b_in = v2.b; ci_in = v2.ci;
        wait_done(dcyc);
        check("b2b_first_cycle", OW'(dcyc), OW'(LAT));
        pop_and_compare("b2b_first");
        tick();
        start = 1'b0;
        a_in = rnd_op(); b_in = rnd_op();
        check("b2b_accept_busy", {{(OW-1){1'b0}}, busy}, {{(OW-1){1'b0}}, 1'b1});
        wait_done(dcyc);
        check("b2b_second_cycle", OW'(dcyc), OW'(LAT));
        pop_and_compare("b2b_second");
        tick();
        check("b2b_end_done", {{(OW-1){1'b0}}, done}, '0);
        check("sb_empty", OW'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rca_mw_seq
